// File: rtl/echo_pkg.sv
// Shared widths, FSM encoding and saturation limits for the echo effect.
// Pure declarations: no latency, no backpressure.
package echo_pkg;
   localparam int ECHO_DATA_W  = 16;
   localparam int ECHO_ADDR_W  = 12;
   localparam int ECHO_SAT_MAX = (1 << (ECHO_DATA_W - 1)) - 1;
   localparam int ECHO_SAT_MIN = -(1 << (ECHO_DATA_W - 1));

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_CALC = 2'd2,
      S_WR   = 2'd3
   } state_t;
endpackage

// File: rtl/echo_delay_if.sv
// Sample-rate audio port of the echo block: strobe, controls and processed output.
// No handshake: the source holds inputs for a full fs_clk period, output is a valid pulse.
interface echo_delay_if #(
   parameter int DATA_W = echo_pkg::ECHO_DATA_W,
   parameter int ADDR_W = echo_pkg::ECHO_ADDR_W
);
   logic                     fs_clk;
   logic signed [DATA_W-1:0] sample_in;
   logic [ADDR_W-1:0]        delay_len;
   logic [2:0]               atten;
   logic                     fx_en;
   logic signed [DATA_W-1:0] sample_out;
   logic                     out_valid;
   logic                     overrun;

   modport master (
      output fs_clk, sample_in, delay_len, atten, fx_en,
      input  sample_out, out_valid, overrun
   );

   modport slave (
      input  fs_clk, sample_in, delay_len, atten, fx_en,
      output sample_out, out_valid, overrun
   );
endinterface

// File: rtl/delay_ram.sv
// Single-port synchronous echo buffer, 2^ADDR_W x DATA_W.
// Read data valid one cycle after the address; no backpressure, one access per cycle.
module delay_ram #(
   parameter int DATA_W = echo_pkg::ECHO_DATA_W,
   parameter int ADDR_W = echo_pkg::ECHO_ADDR_W
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        addr,
   input  logic signed [DATA_W-1:0] wdata,
   output logic signed [DATA_W-1:0] rdata
);
   logic signed [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/echo_delay.sv
// Feedback echo: out = sat(in + buf[n - delay] >>> atten), result written back to the buffer.
// Output 3 clk after each fs_clk tick; no backpressure, ticks arriving while busy are dropped (overrun).
module echo_delay
   import echo_pkg::*;
#(
   parameter int DATA_W = ECHO_DATA_W,
   parameter int ADDR_W = ECHO_ADDR_W
) (
   input  logic        clk,
   input  logic        rst_n,
   echo_delay_if.slave io
);
   localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W - 1){1'b1}}};
   localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W - 1){1'b0}}};

   logic                     sync1, sync2, sync3, tick;
   state_t                   state, state_nxt;
   logic                     ram_we, do_latch, do_out;
   logic [ADDR_W-1:0]        wr_ptr, ram_addr, lat_delay;
   logic [ADDR_W:0]          fill;
   logic [2:0]               lat_atten;
   logic                     lat_fx;
   logic signed [DATA_W-1:0] lat_sample, ram_rdata, delayed, shifted, result, sample_out;
   logic signed [DATA_W:0]   sum;
   logic                     out_valid, overrun;

   assign tick          = sync2 & ~sync3;
   assign io.sample_out = sample_out;
   assign io.out_valid  = out_valid;
   assign io.overrun    = overrun;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (tick) state_nxt = S_RD;
         S_RD:    state_nxt = S_CALC;
         S_CALC:  state_nxt = S_WR;
         S_WR:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The read address uses the live delay_len in the same cycle it is latched.
   always_comb begin
      ram_we   = 1'b0;
      ram_addr = wr_ptr - io.delay_len;
      do_latch = 1'b0;
      do_out   = 1'b0;
      case (state)
         S_RD:   do_latch = 1'b1;
         S_CALC: do_out   = 1'b1;
         S_WR: begin
            ram_we   = 1'b1;
            ram_addr = wr_ptr;
         end
         default: ;
      endcase
   end

   // Stale RAM contents after reset stay hidden until fill covers the delay.
   always_comb begin
      delayed = '0;
      if (lat_delay != '0 && fill >= {1'b0, lat_delay}) delayed = ram_rdata;
      shifted = delayed >>> lat_atten;
      sum     = {lat_sample[DATA_W-1], lat_sample} + {shifted[DATA_W-1], shifted};
      result  = sum[DATA_W-1:0];
      if (!lat_fx)                            result = lat_sample;
      else if (sum[DATA_W] != sum[DATA_W-1])  result = sum[DATA_W] ? SAT_MIN : SAT_MAX;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         sync3      <= 1'b0;
         wr_ptr     <= '0;
         fill       <= '0;
         sample_out <= '0;
         out_valid  <= 1'b0;
         overrun    <= 1'b0;
         lat_sample <= '0;
         lat_delay  <= '0;
         lat_atten  <= '0;
         lat_fx     <= 1'b0;
      end else begin
         sync1     <= io.fs_clk;
         sync2     <= sync1;
         sync3     <= sync2;
         out_valid <= do_out;
         if (tick && state != S_IDLE) overrun <= 1'b1;
         if (do_latch) begin
            lat_sample <= io.sample_in;
            lat_delay  <= io.delay_len;
            lat_atten  <= io.atten;
            lat_fx     <= io.fx_en;
         end
         if (do_out) sample_out <= result;
         if (ram_we) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (!fill[ADDR_W]) fill <= fill + 1'b1;
         end
      end
   end

   delay_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (sample_out),
      .rdata (ram_rdata)
   );
endmodule

// File: tb/tb_echo_delay.sv
// Bench for echo_delay: directed cases plus random samples against a queue-based echo model.
module tb_echo_delay;
   import echo_pkg::*;

   localparam int DW   = ECHO_DATA_W;
   localparam int AW   = ECHO_ADDR_W;
   localparam int SMAX = (1 << (DW - 1)) - 1;
   localparam int SMIN = -(1 << (DW - 1));

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   echo_delay_if #(.DATA_W(DW), .ADDR_W(AW)) io ();

   echo_delay #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int hist[$];
   int exp_q[$];
   int obs[$];
   bit prev_v = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int obs_at(input int i);
      if (i < obs.size()) return obs[i];
      return -999999;
   endfunction

   // Output n = in + (output n-d >>> atten), clamped; only once d earlier outputs exist.
   task automatic model(input int x, input int d, input int a, input bit f, output int r);
      int n;
      int dl;
      int s;
      n  = hist.size();
      dl = 0;
      if (d != 0 && n >= d) dl = hist[n - d];
      s = x + (dl >>> a);
      if (s > SMAX) s = SMAX;
      if (s < SMIN) s = SMIN;
      r = f ? s : x;
      hist.push_back(r);
   endtask

   always @(negedge clk) begin
      if (rst_n && io.out_valid) begin
         obs.push_back(int'(io.sample_out));
         chk("valid_single_cycle", int'(prev_v), 0);
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_out_valid: got sample_out %0d, expected no pulse", int'(io.sample_out));
         end else begin
            chk("sample_out", int'(io.sample_out), exp_q.pop_front());
         end
      end
      prev_v = rst_n && io.out_valid;
   end

   task automatic set_in(input int x, input int d, input int a, input bit f);
      io.sample_in = DW'(x);
      io.delay_len = AW'(d);
      io.atten     = 3'(a);
      io.fx_en     = f;
   endtask

   task automatic send(input int x, input int d, input int a, input bit f);
      int r;
      model(x, d, a, f, r);
      exp_q.push_back(r);
      set_in(x, d, a, f);
      io.fs_clk = 1'b1;
      repeat (4) @(negedge clk);
      io.fs_clk = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      io.fs_clk = 1'b0;
      repeat (3) @(negedge clk);
      hist.delete();
      exp_q.delete();
      obs.delete();
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1000000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int lat;
      int r;
      int x;
      int imp_exp[13];

      rst_n = 1'b1;
      io.fs_clk = 1'b0;
      set_in(0, 0, 0, 1'b0);
      #1 rst_n = 1'b0;
      #20;
      chk("rst_sample_out", int'(io.sample_out), 0);
      chk("rst_out_valid", int'(io.out_valid), 0);
      chk("rst_overrun", int'(io.overrun), 0);
      do_reset();

      // Latency and first-sample value with an empty buffer.
      model(1000, 4, 0, 1'b1, r);
      exp_q.push_back(r);
      set_in(1000, 4, 0, 1'b1);
      io.fs_clk = 1'b1;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (io.out_valid && lat == 0) lat = k;
      end
      chk("latency_edges", lat, 5);
      io.fs_clk = 1'b0;
      repeat (4) @(negedge clk);
      chk("first_out", obs_at(0), 1000);

      // Impulse with feedback halves every 4 samples.
      do_reset();
      imp_exp = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
      send(1000, 4, 1, 1'b1);
      for (int i = 1; i < 13; i++) send(0, 4, 1, 1'b1);
      for (int i = 0; i < 13; i++) chk("impulse", obs_at(i), imp_exp[i]);

      // Saturation both ways, then bypass and zero delay.
      do_reset();
      send(30000, 1, 0, 1'b1);
      send(30000, 1, 0, 1'b1);
      chk("sat_pos", obs_at(1), 32767);
      do_reset();
      send(-30000, 1, 0, 1'b1);
      send(-30000, 1, 0, 1'b1);
      chk("sat_neg", obs_at(1), -32768);
      send(5000, 1, 0, 1'b0);
      send(100, 1, 0, 1'b1);
      send(777, 0, 0, 1'b1);
      chk("bypass_fx_off", obs_at(2), 5000);
      chk("echo_of_bypass", obs_at(3), 5100);
      chk("delay_zero", obs_at(4), 777);

      // Second rising edge lands in CALC: dropped, overrun sticks.
      do_reset();
      chk("overrun_clear", int'(io.overrun), 0);
      model(1234, 4, 0, 1'b1, r);
      exp_q.push_back(r);
      set_in(1234, 4, 0, 1'b1);
      io.fs_clk = 1'b1;
      @(negedge clk);
      io.fs_clk = 1'b0;
      @(negedge clk);
      io.fs_clk = 1'b1;
      repeat (6) @(negedge clk);
      io.fs_clk = 1'b0;
      repeat (4) @(negedge clk);
      chk("overrun_set", int'(io.overrun), 1);
      chk("overrun_one_output", obs.size(), 1);
      send(50, 4, 0, 1'b1);
      chk("overrun_sticky", int'(io.overrun), 1);
      chk("after_overrun", obs_at(1), 50);

      // Reset while in CALC aborts the sample.
      do_reset();
      set_in(4321, 1, 0, 1'b1);
      io.fs_clk = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      io.fs_clk = 1'b0;
      #1;
      chk("abort_out_valid", int'(io.out_valid), 0);
      chk("abort_sample_out", int'(io.sample_out), 0);
      repeat (2) @(negedge clk);
      hist.delete();
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_output", obs.size(), 0);
      send(2222, 4, 2, 1'b1);
      chk("after_abort", obs_at(0), 2222);

      // Random controls, delay changing between samples.
      do_reset();
      for (int i = 0; i < 300; i++) begin
         x = int'($urandom_range(65535)) - 32768;
         send(x, int'($urandom_range(8)), int'($urandom_range(7)), 1'(($urandom_range(3) != 0)));
      end

      // Full-depth delay across the pointer wrap.
      do_reset();
      send(1000, 4095, 1, 1'b1);
      for (int i = 1; i < 4095; i++) send(int'($urandom_range(4000)) - 2000, 4095, 1, 1'b1);
      send(0, 4095, 1, 1'b1);
      for (int i = 0; i < 4; i++) send(int'($urandom_range(4000)) - 2000, 4095, 1, 1'b1);
      chk("wrap_echo", obs_at(4095), 500);

      repeat (10) @(negedge clk);
      chk("pending_expected", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/echo_delay.md
ECHO_DELAY -- requirements
Module: echo_delay

Interface
REQ-001 SHALL have parameter DATA_W, default 16, signed audio sample width.
REQ-002 SHALL have parameter ADDR_W, default 12, delay-buffer address width (4096 samples, ~100 ms at ~40.3 kHz).
REQ-003 SHALL have port clk  in  1  system clock (50 MHz); the single clock of the block.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port fs_clk  in  1  divided sample-rate clock from the frequency divider, treated as data and sampled in clk.
REQ-006 SHALL have port sample_in  in  DATA_W  signed input sample, held stable by the source across an fs_clk period.
REQ-007 SHALL have port delay_len  in  ADDR_W  echo delay in samples; 0 means bypass.
REQ-008 SHALL have port atten  in  3  feedback attenuation as an arithmetic right-shift amount, 0..7.
REQ-009 SHALL have port fx_en  in  1  1 = echo applied, 0 = dry pass-through.
REQ-010 SHALL have port sample_out  out  DATA_W  signed processed sample, registered.
REQ-011 SHALL have port out_valid  out  1  single-cycle pulse marking a new sample_out.
REQ-012 SHALL have port overrun  out  1  sticky flag: a sample tick was dropped.

Function
REQ-013 SHALL synchronize fs_clk through two flops and generate tick = sync2 & ~sync3, one clk cycle per fs_clk rising edge.
REQ-014 SHALL run FSM IDLE -> RD -> CALC -> WR -> IDLE, one state per clk cycle; leave IDLE only on tick.
REQ-015 RD: latch sample_in, delay_len, atten, fx_en; issue RAM read at rd_addr = (wr_ptr - delay_len) mod 2^ADDR_W.
REQ-016 CALC: delayed = RAM data if fill >= delay_len and delay_len != 0, else 0; sum = sample_in + (delayed >>> atten) at DATA_W+1 bits.
REQ-017 Saturate sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; no wrap-around permitted.
REQ-018 If latched fx_en = 0, result = latched sample_in unchanged.
REQ-019 On CALC -> WR edge: sample_out <= result, out_valid <= 1 for exactly one cycle.
REQ-020 WR: write result to RAM at wr_ptr (feedback echo, also in bypass); then wr_ptr increments mod 2^ADDR_W and fill increments, saturating at 2^ADDR_W.
REQ-021 Latency: out_valid high exactly 3 clk cycles after the tick cycle; 5 clk edges after the first edge sampling fs_clk high.
REQ-022 tick while FSM not IDLE SHALL be dropped and set overrun; overrun clears only on reset.
REQ-023 delay_len change between ticks SHALL take effect on the next tick only; no mid-sample change.

Reset
REQ-024 rst_n low SHALL immediately clear FSM to IDLE, sync flops, wr_ptr, fill, sample_out, out_valid, overrun to 0.
REQ-025 Reset mid-operation SHALL abort the sample with no RAM write and no out_valid; RAM contents need not be cleared (fill gating hides stale data).
REQ-026 First tick after rst_n release SHALL be processed normally.

Structure
REQ-027 Shared package echo_pkg SHALL hold DATA_W, ADDR_W defaults, the FSM state enum, and saturation limit constants.
REQ-028 Buffer SHALL be sub-module delay_ram: single-port synchronous RAM, 2^ADDR_W x DATA_W, 1-cycle read latency, write-enable port.

Verification
REQ-029 Reset, fs_clk rise, sample_in=1000, fx_en=1, delay_len=4 -> out_valid pulse 3 cycles after tick, sample_out=1000 (fill<4).
REQ-030 Impulse 1000 then zeros, delay_len=4, atten=1 -> sample_out sequence 1000,0,0,0,500,0,0,0,250,... (feedback).
REQ-031 sample_in=30000, delayed 30000, atten=0 -> sample_out=32767; negative case -30000 pair -> -32768.
REQ-032 fs_clk toggled faster so tick arrives in CALC -> overrun=1 and stays 1, dropped sample produces no out_valid.
REQ-033 Run 4100 samples with delay_len=4095 -> wr_ptr wraps 4095->0, echo of sample n appears at n+4095 with correct value.
REQ-034 rst_n pulsed low during CALC -> no out_valid, outputs 0, next tick after release gives sample_out=sample_in.
